button_press_array: RTL and testbench
=====================================

# button_press_array

Multi-channel front end for push-buttons. Each channel synchronises an asynchronous raw button, debounces it against a shared tick strobe, and emits one-cycle press and release pulses plus a long-press pulse and optional auto-repeat pulses. It sits between the board pins and the stop-watch control FSM, and replaces per-button single-pulse units with one parametrised array.

## Interface
- CHANNELS, 4: number of independent buttons.
- SYNC_STAGES, 2: synchroniser flip-flops per channel (≥2).
- DEBOUNCE_TICKS, 4: consecutive stable ticks needed to accept a level change (≥1).
- LONG_TICKS, 200: ticks held (counted from press acceptance) before `long_pulse` fires (> DEBOUNCE_TICKS).
- REPEAT_TICKS, 50: tick period of `repeat_pulse` after the long press (≥1).
- BUTTON_ACTIVE_LOW, 0: 1 = raw input reads 0 when pressed.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- tick_en  in  1  one-cycle debounce/timing strobe from the shared timer.
- repeat_en  in  CHANNELS  per-channel auto-repeat enable.
- button_in  in  CHANNELS  raw asynchronous buttons.
- pressed  out  CHANNELS  debounced level, 1 = pressed.
- press_pulse  out  CHANNELS  one-cycle pulse on accepted press.
- release_pulse  out  CHANNELS  one-cycle pulse on accepted release.
- long_pulse  out  CHANNELS  one-cycle pulse, once per hold, at LONG_TICKS.
- repeat_pulse  out  CHANNELS  one-cycle pulse every REPEAT_TICKS after the long press.

## Operation
- Channels are fully independent. `tick_en` and `clk` are shared.
- Raw input is inverted when BUTTON_ACTIVE_LOW=1, then passed through SYNC_STAGES flops. The result is `s`.
- Per-channel FSM states:
  - IDLE: `s`=1 → DEB_PRESS, counter cleared.
  - DEB_PRESS: `s`=0 → IDLE, counter cleared. On a tick with `s`=1 the counter increments. When it reaches DEBOUNCE_TICKS → HELD, `press_pulse` fires, counter cleared.
  - HELD: counter increments on each tick. When it reaches LONG_TICKS → LONG, `long_pulse` fires, counter cleared. `s`=0 → DEB_RELEASE.
  - LONG: if `repeat_en`, the counter increments on each tick. When it reaches REPEAT_TICKS, `repeat_pulse` fires and the counter clears. `s`=0 → DEB_RELEASE.
  - DEB_RELEASE: `s`=1 → return to the state held before (HELD or LONG), with the counter cleared. The long-press is not re-armed. On a tick with `s`=0 the counter increments. When it reaches DEBOUNCE_TICKS → IDLE, `release_pulse` fires.
- `pressed` = 1 in HELD, LONG and DEB_RELEASE.
- Any bounce during debounce restarts the count. No partial credit.
- Deasserting `repeat_en` in LONG freezes and clears the repeat counter. Reasserting it starts a full REPEAT_TICKS period.
- Counter width = clog2(max(DEBOUNCE_TICKS, LONG_TICKS, REPEAT_TICKS)+1). The counter never wraps. Each compare clears it.

## Timing
- Reset (reset=0, asynchronous): all synchroniser flops = 0 after polarity inversion (button released), FSM = IDLE, counters = 0, all outputs = 0.
- Synchroniser latency: SYNC_STAGES clk cycles from the raw edge to `s`.
- All outputs are registered. A pulse is high for exactly one clk cycle: the cycle after the clk edge on which the triggering tick was sampled.
- Press latency (clean edge): SYNC_STAGES cycles, plus the wait for DEBOUNCE_TICKS ticks, plus 1 cycle.
- Simultaneous events in one cycle: `s` change and tick. The `s` change wins: the state transitions and no increment occurs.
- If `tick_en` is held high continuously, every cycle counts as a tick. The behaviour stays well defined.
- Reset asserted mid-hold: outputs drop to 0 immediately. No release pulse is emitted.
- Release is emitted even if `long_pulse` already fired. `press_pulse` and `release_pulse` never occur in the same cycle on one channel.

## Structure
- Package `button_pkg`:
  - FSM state encoding (IDLE, DEB_PRESS, HELD, LONG, DEB_RELEASE).
  - Counter-width helper function.
- Sub-module `button_channel`: synchroniser, FSM, counter and output registers for a single channel.
- Top level: a generate loop over CHANNELS plus polarity inversion. No shared state beyond `tick_en`.

## Test plan
- Clean press then release, DEBOUNCE_TICKS=4, tick every 8 cycles, hold 100 cycles → exactly one press_pulse and one release_pulse; `pressed` high between them; latencies match the formula.
- Bounce: toggle the raw input 3 times with sub-tick spacing, then hold → a single press_pulse, 4 ticks after the last toggle.
- Long and repeat, LONG_TICKS=10, REPEAT_TICKS=3, repeat_en=1, held for 20 ticks after acceptance → long_pulse at tick 10; repeat_pulse at ticks 13, 16 and 19; no press_pulse repeats.
- Repeat disabled mid-hold → no further repeat_pulse; after re-enable, the first pulse comes a full 3 ticks later.
- Multi-channel: channel 0 pressed and channel 2 released in the same cycle, with BUTTON_ACTIVE_LOW=1 → independent, correct pulses; channels 1 and 3 stay silent.
- Asynchronous reset asserted in LONG → all outputs 0 without waiting for a clk edge; after release the channel behaves as a fresh press with the button held, so a new press_pulse follows debounce.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types and helpers for the push-button front end.
package button_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_DEB_PRESS   = 3'd1,
        ST_HELD        = 3'd2,
        ST_LONG        = 3'd3,
        ST_DEB_RELEASE = 3'd4
    } state_e;

    // Width holding the largest terminal count without wrapping.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/button_press_array_if.sv
// Pin-side bundle of the button array: shared strobe, raw inputs and event outputs.
interface button_press_array_if #(
    parameter int unsigned CHANNELS = 4
);
    logic                tick_en;
    logic [CHANNELS-1:0] repeat_en;
    logic [CHANNELS-1:0] button_in;
    logic [CHANNELS-1:0] pressed;
    logic [CHANNELS-1:0] press_pulse;
    logic [CHANNELS-1:0] release_pulse;
    logic [CHANNELS-1:0] long_pulse;
    logic [CHANNELS-1:0] repeat_pulse;

    modport master (
        output tick_en, repeat_en, button_in,
        input  pressed, press_pulse, release_pulse, long_pulse, repeat_pulse
    );

    modport slave (
        input  tick_en, repeat_en, button_in,
        output pressed, press_pulse, release_pulse, long_pulse, repeat_pulse
    );
endinterface

// File: rtl/button_channel.sv
// One button: synchroniser, debounce/long/repeat FSM and registered event outputs.
module button_channel
    import button_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned DEBOUNCE_TICKS = 4,
    parameter int unsigned LONG_TICKS     = 200,
    parameter int unsigned REPEAT_TICKS   = 50
) (
    input  logic clk,
    input  logic reset,
    input  logic tick_en,
    input  logic repeat_en,
    input  logic btn,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_TICKS, LONG_TICKS, REPEAT_TICKS);
    localparam logic [CW-1:0] DEB_MAX  = CW'(DEBOUNCE_TICKS);
    localparam logic [CW-1:0] LONG_MAX = CW'(LONG_TICKS);
    localparam logic [CW-1:0] REP_MAX  = CW'(REPEAT_TICKS);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
    logic                   from_long_q, from_long_d;
    logic                   pressed_q, pressed_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   long_q, long_d;
    logic                   repeat_q, repeat_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    // A level change on s takes priority over a coincident tick.
    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], btn};
        state_d     = state_q;
        cnt_d       = cnt_q;
        from_long_d = from_long_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        repeat_d    = 1'b0;
        cnt_inc     = cnt_q + CW'(1);
        case (state_q)
            ST_IDLE: begin
                if (s) begin
                    state_d = ST_DEB_PRESS;
                    cnt_d   = '0;
                end
            end
            ST_DEB_PRESS: begin
                if (!s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (tick_en) begin
                    if (cnt_inc == DEB_MAX) begin
                        state_d     = ST_HELD;
                        press_d     = 1'b1;
                        cnt_d       = '0;
                        from_long_d = 1'b0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            ST_HELD: begin
                if (!s) begin
                    state_d     = ST_DEB_RELEASE;
                    cnt_d       = '0;
                    from_long_d = 1'b0;
                end else if (tick_en) begin
                    if (cnt_inc == LONG_MAX) begin
                        state_d = ST_LONG;
                        long_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            ST_LONG: begin
                if (!s) begin
                    state_d     = ST_DEB_RELEASE;
                    cnt_d       = '0;
                    from_long_d = 1'b1;
                end else if (!repeat_en) begin
                    cnt_d = '0;
                end else if (tick_en) begin
                    if (cnt_inc == REP_MAX) begin
                        repeat_d = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            ST_DEB_RELEASE: begin
                // Bounce back resumes the prior hold state; long press stays consumed.
                if (s) begin
                    state_d = from_long_q ? ST_LONG : ST_HELD;
                    cnt_d   = '0;
                end else if (tick_en) begin
                    if (cnt_inc == DEB_MAX) begin
                        state_d   = ST_IDLE;
                        release_d = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        pressed_d = (state_d == ST_HELD) || (state_d == ST_LONG) ||
                    (state_d == ST_DEB_RELEASE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q      <= '0;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            from_long_q <= 1'b0;
            pressed_q   <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            repeat_q    <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            from_long_q <= from_long_d;
            pressed_q   <= pressed_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            repeat_q    <= repeat_d;
        end
    end

    assign pressed       = pressed_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;
    assign repeat_pulse  = repeat_q;

endmodule

// File: rtl/button_press_array.sv
// Array of independent button channels sharing clk and the tick strobe.
module button_press_array
    import button_pkg::*;
#(
    parameter int unsigned CHANNELS          = 4,
    parameter int unsigned SYNC_STAGES       = 2,
    parameter int unsigned DEBOUNCE_TICKS    = 4,
    parameter int unsigned LONG_TICKS        = 200,
    parameter int unsigned REPEAT_TICKS      = 50,
    parameter bit          BUTTON_ACTIVE_LOW = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    button_press_array_if.slave  bus
);

    logic [CHANNELS-1:0] btn_n;

    always_comb begin
        btn_n = BUTTON_ACTIVE_LOW ? ~bus.button_in : bus.button_in;
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        button_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
            .LONG_TICKS     (LONG_TICKS),
            .REPEAT_TICKS   (REPEAT_TICKS)
        ) u_ch (
            .clk           (clk),
            .reset         (reset),
            .tick_en       (bus.tick_en),
            .repeat_en     (bus.repeat_en[i]),
            .btn           (btn_n[i]),
            .pressed       (bus.pressed[i]),
            .press_pulse   (bus.press_pulse[i]),
            .release_pulse (bus.release_pulse[i]),
            .long_pulse    (bus.long_pulse[i]),
            .repeat_pulse  (bus.repeat_pulse[i])
        );
    end

endmodule

// File: tb/tb_button_press_array.sv
// Directed bench for button_press_array: active-low buttons, DEB=4, LONG=10, REPEAT=3.
module tb_button_press_array;

    localparam int unsigned NCH = 4;

    logic clk;
    logic reset;

    button_press_array_if #(.CHANNELS(NCH)) bus_if ();

    button_press_array #(
        .CHANNELS          (NCH),
        .SYNC_STAGES       (2),
        .DEBOUNCE_TICKS    (4),
        .LONG_TICKS        (10),
        .REPEAT_TICKS      (3),
        .BUTTON_ACTIVE_LOW (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Monitor: cycle/tick counters and per-channel event logs.
    int unsigned cyc = 0;
    int unsigned ticks = 0;
    int unsigned n_press   [NCH] = '{default: 0};
    int unsigned n_rel     [NCH] = '{default: 0};
    int unsigned n_long    [NCH] = '{default: 0};
    int unsigned n_rep     [NCH] = '{default: 0};
    int unsigned n_pressed [NCH] = '{default: 0};
    int unsigned press_cyc [NCH] = '{default: 0};
    int unsigned press_tick[NCH] = '{default: 0};
    int unsigned rel_cyc   [NCH] = '{default: 0};
    int unsigned rel_tick  [NCH] = '{default: 0};
    int unsigned long_tick [NCH] = '{default: 0};
    int unsigned both_cnt = 0;
    int unsigned rep_q[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus_if.tick_en) ticks <= ticks + 1;
    end

    always @(negedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (bus_if.press_pulse[c]) begin
                n_press[c]    <= n_press[c] + 1;
                press_cyc[c]  <= cyc;
                press_tick[c] <= ticks;
            end
            if (bus_if.release_pulse[c]) begin
                n_rel[c]    <= n_rel[c] + 1;
                rel_cyc[c]  <= cyc;
                rel_tick[c] <= ticks;
            end
            if (bus_if.long_pulse[c]) begin
                n_long[c]    <= n_long[c] + 1;
                long_tick[c] <= ticks;
            end
            if (bus_if.repeat_pulse[c]) begin
                n_rep[c] <= n_rep[c] + 1;
                if (c == 0) rep_q.push_back(ticks);
            end
            if (bus_if.pressed[c]) n_pressed[c] <= n_pressed[c] + 1;
            if (bus_if.press_pulse[c] && bus_if.release_pulse[c]) both_cnt <= both_cnt + 1;
        end
    end

    // Stimulus helpers: one tick every tick_per cycles, phase restartable.
    int unsigned tick_per = 8;
    int unsigned tick_div = 0;
    int unsigned base_c = 0;
    int unsigned base_t = 0;

    task automatic run(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
            bus_if.tick_en = (tick_div == tick_per - 1);
            tick_div = (tick_div == tick_per - 1) ? 0 : tick_div + 1;
        end
    endtask

    task automatic mark();
        tick_div = 0;
        bus_if.tick_en = 1'b0;
        base_c = cyc;
        base_t = ticks;
    endtask

    task automatic btn(input int c, input bit down);
        bus_if.button_in[c] = ~down;
    endtask

    function automatic int unsigned rq(input int unsigned i);
        return (rep_q.size() > i) ? rep_q[i] : 0;
    endfunction

    function automatic int unsigned outs();
        return {bus_if.press_pulse, bus_if.release_pulse, bus_if.long_pulse, bus_if.repeat_pulse};
    endfunction

    initial begin
        int unsigned sp, sr, sl, spd, rb, sp1, sr1, sp3, sr3;
        reset = 1'b0;
        bus_if.button_in = '1;
        bus_if.repeat_en = '0;
        bus_if.tick_en   = 1'b0;
        #23;
        check("rst_pressed", bus_if.pressed, 0);
        check("rst_pulses", outs(), 0);
        reset = 1'b1;
        run(10);
        check("idle_pressed", bus_if.pressed, 0);
        check("idle_presses", n_press[0] + n_press[1] + n_press[2] + n_press[3], 0);

        // Clean press / release on channel 0.
        mark();
        sp = n_press[0]; sr = n_rel[0]; sl = n_long[0]; spd = n_pressed[0];
        btn(0, 1);
        run(100);
        btn(0, 0);
        run(40);
        check("s1_press_cnt", n_press[0] - sp, 1);
        check("s1_press_lat", press_cyc[0] - base_c, 33);
        check("s1_press_tick", press_tick[0] - base_t, 4);
        check("s1_rel_cnt", n_rel[0] - sr, 1);
        check("s1_rel_lat", rel_cyc[0] - base_c, 129);
        check("s1_rel_tick", rel_tick[0] - base_t, 16);
        check("s1_long_cnt", n_long[0] - sl, 0);
        check("s1_pressed_cyc", n_pressed[0] - spd, 96);

        // Bounce on channel 1: first tick's credit must be discarded.
        mark();
        sp = n_press[1]; sr = n_rel[1];
        btn(1, 1);
        run(7);
        btn(1, 0);
        run(2);
        btn(1, 1);
        run(35);
        btn(1, 0);
        run(50);
        check("s2_press_cnt", n_press[1] - sp, 1);
        check("s2_press_lat", press_cyc[1] - base_c, 41);
        check("s2_press_tick", press_tick[1] - base_t, 5);
        check("s2_rel_cnt", n_rel[1] - sr, 1);

        // Long press and auto-repeat on channel 0.
        bus_if.repeat_en[0] = 1'b1;
        mark();
        sp = n_press[0]; sr = n_rel[0]; sl = n_long[0]; rb = rep_q.size();
        btn(0, 1);
        run(194);
        btn(0, 0);
        run(40);
        check("s3_press_cnt", n_press[0] - sp, 1);
        check("s3_long_cnt", n_long[0] - sl, 1);
        check("s3_long_tick", long_tick[0] - base_t, 14);
        check("s3_rep_cnt", rep_q.size() - rb, 3);
        check("s3_rep0_tick", rq(rb) - base_t, 17);
        check("s3_rep1_tick", rq(rb + 1) - base_t, 20);
        check("s3_rep2_tick", rq(rb + 2) - base_t, 23);
        check("s3_rel_cnt", n_rel[0] - sr, 1);

        // Repeat disabled mid-hold, then re-enabled.
        mark();
        sl = n_long[0]; rb = rep_q.size(); sr = n_rel[0];
        btn(0, 1);
        run(146);
        bus_if.repeat_en[0] = 1'b0;
        run(34);
        bus_if.repeat_en[0] = 1'b1;
        run(30);
        btn(0, 0);
        run(50);
        bus_if.repeat_en[0] = 1'b0;
        check("s4_long_cnt", n_long[0] - sl, 1);
        check("s4_rep_cnt", rep_q.size() - rb, 2);
        check("s4_rep0_tick", rq(rb) - base_t, 17);
        check("s4_rep1_tick", rq(rb + 1) - base_t, 25);
        check("s4_rel_cnt", n_rel[0] - sr, 1);

        // Channel 0 press and channel 2 release in the same cycle.
        mark();
        btn(2, 1);
        run(40);
        mark();
        sp = n_press[0]; sr = n_rel[0]; sp1 = n_press[2]; sr1 = n_rel[2]; sl = n_long[0];
        sp3 = n_press[1] + n_rel[1] + n_long[1] + n_rep[1] + n_press[3] + n_rel[3] + n_long[3] + n_rep[3];
        btn(0, 1);
        btn(2, 0);
        run(120);
        check("s5_ch0_press_cnt", n_press[0] - sp, 1);
        check("s5_ch0_press_lat", press_cyc[0] - base_c, 33);
        check("s5_ch2_rel_cnt", n_rel[2] - sr1, 1);
        check("s5_ch2_rel_lat", rel_cyc[2] - base_c, 33);
        check("s5_ch2_press_cnt", n_press[2] - sp1, 0);
        check("s5_ch0_long_cnt", n_long[0] - sl, 1);
        check("s5_quiet_ch13", n_press[1] + n_rel[1] + n_long[1] + n_rep[1] + n_press[3] + n_rel[3] + n_long[3] + n_rep[3] - sp3, 0);
        check("s5_pressed", bus_if.pressed, 4'b0001);

        // Asynchronous reset while channel 0 sits in LONG.
        #2;
        reset = 1'b0;
        #1;
        check("s6_async_pressed", bus_if.pressed, 0);
        check("s6_async_pulses", outs(), 0);
        run(2);
        check("s6_no_rel", n_rel[0] - sr, 0);
        reset = 1'b1;
        mark();
        sp = n_press[0];
        run(40);
        check("s6_press_cnt", n_press[0] - sp, 1);
        check("s6_press_lat", press_cyc[0] - base_c, 33);
        sr = n_rel[0];
        btn(0, 0);
        run(50);
        check("s6_rel_cnt", n_rel[0] - sr, 1);

        // Continuous tick on channel 3: level change beats the coincident tick.
        tick_per = 1;
        mark();
        sp3 = n_press[3]; sr3 = n_rel[3];
        btn(3, 1);
        run(8);
        btn(3, 0);
        run(20);
        tick_per = 8;
        check("s7_press_lat", press_cyc[3] - base_c, 7);
        check("s7_rel_lat", rel_cyc[3] - base_c, 15);
        check("s7_counts", (n_press[3] - sp3) * 16 + (n_rel[3] - sr3), 17);

        run(5);
        check("end_both_same_cycle", both_cnt, 0);
        check("end_pressed", bus_if.pressed, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
